stream_arbiter_rr: RTL
======================

Name: stream_arbiter_rr

Overview:
- N-to-1 stream arbiter with data; the counterpart of the stream demultiplexer. It merges N_INP valid-ready input streams onto one output stream.
- Fair round-robin selection.
- A grant stays locked while the output is stalled, so the output stream obeys the stable-valid/stable-data rule.
- Used wherever several requesters share one downstream stream port, e.g. a shared memory request port.

Parameters:
- N_INP, 4, number of input streams; must be >= 1.
- DATA_WIDTH, 32, width of each stream's payload.
- IDX_WIDTH, derived, = max(1, $clog2(N_INP)); must not be overridden.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous reset, active-high.
- inp_valid_i  input  N_INP  per-input valid.
- inp_ready_o  output  N_INP  per-input ready.
- inp_data_i  input  N_INP*DATA_WIDTH  packed payloads; input k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- oup_valid_o  output  1  output valid.
- oup_ready_i  input  1  output ready.
- oup_data_o  output  DATA_WIDTH  payload of the granted input.
- oup_idx_o  output  IDX_WIDTH  index of the granted input; meaningful only when oup_valid_o=1.

Behaviour:
- Interface (decided): one clock, clk_i; reset rst_i is synchronous and active-high.
- State:
  - rr_q (IDX_WIDTH): round-robin start pointer.
  - lock_q (1): grant-locked flag.
  - lock_idx_q (IDX_WIDTH): locked input index.
- Reset values: rr_q=0, lock_q=0, lock_idx_q=0.
- Outputs while rst_i=1: oup_valid_o=0, inp_ready_o=0, oup_idx_o=0, oup_data_o=0.
- Zero latency: the output path is combinational from the inputs and state; no data register.
- Unlocked selection: idx = first k with inp_valid_i[k]=1, scanning rr_q, rr_q+1, ..., N_INP-1, 0, ..., rr_q-1.
- Locked selection: idx = lock_idx_q, regardless of the other valids.
- oup_valid_o = inp_valid_i[idx] if locked, otherwise OR of all inp_valid_i.
- oup_data_o = inp_data_i[idx]; oup_idx_o = idx.
- inp_ready_o[k] = oup_ready_i AND oup_valid_o AND (k == idx). All other bits are 0, and no ready goes to a non-granted input.
- inp_ready_o does not depend on any inp_valid_i except through idx selection. oup_valid_o never depends on oup_ready_i.
- Lock update each cycle:
  - lock_q <= oup_valid_o AND NOT oup_ready_i.
  - lock_idx_q <= idx when it becomes or stays locked.
- Lock release:
  - On handshake (oup_valid_o AND oup_ready_i), lock clears.
  - If the locked input drops valid (a protocol violation by the upstream), lock clears and oup_valid_o=0 that cycle. This is not an error condition.
- Pointer update: on handshake from idx, rr_q <= idx+1, wrapping N_INP-1 -> 0. With no handshake, rr_q holds.
- Fairness: with all inputs continuously valid and oup_ready_i=1, grants go 0,1,...,N_INP-1,0,... with no input granted twice before each other valid input is granted once.
- Non-power-of-two N_INP: the pointer wraps at N_INP-1, never at 2^IDX_WIDTH-1. Indices >= N_INP are never produced.
- N_INP=1: idx constant 0; degenerates to a pass-through with a registered lock; rr_q stays 0.
- Simultaneous new valid on a higher-priority input while locked: no effect until the locked transfer completes.
- Reset mid-transfer: the stalled transfer is abandoned (lock cleared, rr_q=0). The next arbitration after reset starts from input 0.
- Assertions:
  - No inp_ready_o bit asserted to an input with inp_valid_i=0.
  - oup_data_o and oup_idx_o stable while oup_valid_o=1 and oup_ready_i=0, given compliant inputs.
  - At most one inp_ready_o bit high.

Test Plan:
- Reset: N_INP=4, rst_i=1 with all inp_valid_i=1111 and oup_ready_i=1 -> oup_valid_o=0 and inp_ready_o=0000. First cycle after release -> oup_idx_o=0, inp_ready_o=0001.
- Round-robin: all 4 valid, oup_ready_i=1, data k=0xA0+k -> oup_idx_o sequence 0,1,2,3,0,1 and oup_data_o 0xA0,0xA1,0xA2,0xA3,0xA0,0xA1, one per cycle.
- Lock under stall: input 2 valid only, oup_ready_i=0 for 3 cycles; input 0 asserts valid at cycle 1 -> oup_idx_o stays 2 with stable data for 3 cycles. On oup_ready_i=1, input 2 transfers; the next cycle grants input 0 and rr_q=3.
- Wrap with gaps: rr_q=3, valids=0101 -> grant 0, then grant 2, then grant 0 again (rr_q=3 -> scan finds 0).
- Valid drop while locked: input 1 locked with oup_ready_i=0, input 1 deasserts valid -> oup_valid_o=0 that cycle. The next cycle re-arbitrates from rr_q unchanged.
- N_INP=3 / N_INP=1: with N_INP=3 and all valid, the grant sequence is 0,1,2,0 (never 3). With N_INP=1, data passes through with inp_ready_o=oup_ready_i when valid.

Source files
------------

// File: rtl/stream_arbiter_rr.sv
// N-to-1 valid/ready stream arbiter with round-robin fairness.
// The grant is held while the output stalls so the output stream stays stable.
module stream_arbiter_rr #(
    parameter int unsigned N_INP      = 4,
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned IDX_WIDTH = (N_INP > 1) ? $clog2(N_INP) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [N_INP-1:0]            inp_valid_i,
    output logic [N_INP-1:0]            inp_ready_o,
    input  logic [N_INP*DATA_WIDTH-1:0] inp_data_i,
    output logic                        oup_valid_o,
    input  logic                        oup_ready_i,
    output logic [DATA_WIDTH-1:0]       oup_data_o,
    output logic [IDX_WIDTH-1:0]        oup_idx_o
);

    localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(N_INP - 1);

    logic [IDX_WIDTH-1:0]  r_rr;
    logic                  r_lock;
    logic [IDX_WIDTH-1:0]  r_lock_idx;

    logic [IDX_WIDTH-1:0]  w_arb_idx;
    logic [IDX_WIDTH-1:0]  w_idx;
    logic [IDX_WIDTH-1:0]  w_rr_next;
    logic                  w_lock_valid;
    logic                  w_valid;
    logic                  w_hs;
    logic                  w_stall;
    logic [DATA_WIDTH-1:0] w_data;

    // Scan r_rr, r_rr+1, ... modulo N_INP; the first valid input wins.
    always_comb begin
        logic        found;
        int unsigned cand;
        w_arb_idx = r_rr;
        found     = 1'b0;
        for (int unsigned off = 0; off < N_INP; off++) begin
            cand = 32'(r_rr) + off;
            if (cand >= N_INP) begin
                cand = cand - N_INP;
            end
            for (int unsigned k = 0; k < N_INP; k++) begin
                if (!found && (cand == k) && inp_valid_i[k]) begin
                    w_arb_idx = IDX_WIDTH'(k);
                    found     = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_lock_valid = 1'b0;
        for (int unsigned k = 0; k < N_INP; k++) begin
            if (r_lock_idx == IDX_WIDTH'(k)) begin
                w_lock_valid = inp_valid_i[k];
            end
        end
    end

    assign w_idx   = r_lock ? r_lock_idx : w_arb_idx;
    assign w_valid = r_lock ? w_lock_valid : |inp_valid_i;

    always_comb begin
        w_data = '0;
        for (int unsigned k = 0; k < N_INP; k++) begin
            if (w_idx == IDX_WIDTH'(k)) begin
                w_data = inp_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Outputs are forced quiet while reset is held.
    assign oup_valid_o = !rst_i && w_valid;
    assign oup_idx_o   = rst_i ? '0 : w_idx;
    assign oup_data_o  = rst_i ? '0 : w_data;

    always_comb begin
        inp_ready_o = '0;
        for (int unsigned k = 0; k < N_INP; k++) begin
            inp_ready_o[k] = oup_ready_i && oup_valid_o && (w_idx == IDX_WIDTH'(k));
        end
    end

    assign w_hs      = oup_valid_o && oup_ready_i;
    assign w_stall   = oup_valid_o && !oup_ready_i;
    assign w_rr_next = (w_idx == LastIdx) ? '0 : w_idx + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr       <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
        end else begin
            r_lock <= w_stall;
            if (w_stall) begin
                r_lock_idx <= w_idx;
            end
            if (w_hs) begin
                r_rr <= w_rr_next;
            end
        end
    end

`ifndef SYNTHESIS
    a_ready_needs_valid : assert property (@(posedge clk_i)
        (inp_ready_o & ~inp_valid_i) == '0);

    a_ready_onehot : assert property (@(posedge clk_i) $onehot0(inp_ready_o));

    // A dropped valid on the locked input is tolerated, hence the !oup_valid_o escape.
    a_stable_when_stalled : assert property (@(posedge clk_i) disable iff (rst_i)
        (oup_valid_o && !oup_ready_i) |=>
        (!oup_valid_o || ($stable(oup_idx_o) && $stable(oup_data_o))));
`endif

endmodule
